fetch_unit: RTL

- Fetch stage of the 5-stage core.
- Owns the PC register and drives the instruction-bus request/response handshake.
- Produces fetch_data_t on dataF_nxt for the D-register.
- Absorbs decode stalls with a one-entry hold buffer, and takes redirects from pcselect, cancelling or discarding in-flight fetches.

---
 rtl/common_pkg.sv | 6 +
 rtl/pipes_pkg.sv | 16 +
 rtl/fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared scalar/word type aliases used across the core.
package common_pkg;
  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-register payloads and fetch-stage constants.
package pipes_pkg;
  import common_pkg::*;

  localparam u64 PC_RESET  = 64'h0000_0000_8000_0000;
  localparam u32 NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    u1  valid;
    u64 pc;
    u32 raw_instr;
    u1  misalign;
  } fetch_data_t;

  typedef enum logic [1:0] {REQ, HOLD, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, instruction-bus handshake, one-entry stall buffer,
// and redirect handling that lets an in-flight request drain before retargeting.
module fetch_unit
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter u64 PC_RESET  = pipes_pkg::PC_RESET,
  parameter u32 NOP_INSTR = pipes_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallF,
  input  logic        branch_taken,
  input  logic [63:0] pcbranch,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output fetch_data_t dataF_nxt
);

  fetch_state_t state, state_nxt;
  u64 pc, pc_nxt, pend_pc, pend_nxt;
  u32 hold_instr, hold_nxt, instr;
  u1  req_valid, out_valid, misalign;

  assign misalign = (pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= REQ;
      pc         <= PC_RESET;
      pend_pc    <= PC_RESET;
      hold_instr <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_pc    <= pend_nxt;
      hold_instr <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_pc;
    hold_nxt  = hold_instr;
    req_valid = 1'b0;
    out_valid = 1'b0;
    instr     = hold_instr;
    unique case (state)
      REQ: begin
        // A misaligned PC completes its slot locally with a NOP, no bus traffic.
        req_valid = !misalign;
        instr     = misalign ? NOP_INSTR : iresp_data;
        if (misalign || iresp_data_ok) begin
          if (branch_taken) begin
            pc_nxt = pcbranch;
          end else begin
            out_valid = 1'b1;
            if (stallF) begin
              hold_nxt  = instr;
              state_nxt = HOLD;
            end else begin
              pc_nxt = pc + 64'd4;
            end
          end
        end else if (branch_taken) begin
          pend_nxt  = pcbranch;
          state_nxt = DISCARD;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_nxt    = pcbranch;
          state_nxt = REQ;
        end else begin
          out_valid = 1'b1;
          if (!stallF) begin
            pc_nxt    = pc + 64'd4;
            state_nxt = REQ;
          end
        end
      end
      DISCARD: begin
        // The bus forbids withdrawing a request, so keep it up until its beat returns.
        req_valid = 1'b1;
        if (iresp_data_ok) begin
          pc_nxt    = branch_taken ? pcbranch : pend_pc;
          state_nxt = REQ;
        end else if (branch_taken) begin
          pend_nxt = pcbranch;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  // PC is not moved in DISCARD, so it still equals the outstanding request address.
  assign ireq_valid = resetn & req_valid;
  assign ireq_addr  = pc;

  always_comb begin
    dataF_nxt           = '0;
    dataF_nxt.valid     = resetn & out_valid;
    dataF_nxt.pc        = pc;
    dataF_nxt.raw_instr = instr;
    dataF_nxt.misalign  = misalign;
  end

  a_no_unsolicited_beat: assert property (@(posedge clk) disable iff (!resetn)
    !(state == HOLD && iresp_data_ok));

endmodule
